// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between an instruction cache (read-only)
// and a data cache (read/write) in front of one asynchronous memory port.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ic_req_i/ic_addr_i   instruction-cache read request (level, held until ack)
//   dc_req_i/dc_we_i/    data-cache request (level, held until ack),
//   dc_addr_i/dc_wdata_i 1 = write, 0 = read
//   ic_ack_o/dc_ack_o    one-cycle completion pulses
//   rdata_o, err_o       read line and timeout flag, valid in the ack cycle
//   busy_o               high whenever the FSM is not IDLE
//   mem_cs_o/mem_we_o/   memory control; mem_oe_o is the inverse of mem_we_o
//   mem_oe_o             while a transaction is on the bus
//   mem_addr_o/          latched address and write line, stable for the
//   mem_wdata_o          whole ISSUE/BUSY window
//   mem_rdata_i          memory read value
//   mem_ready_i          1 = memory idle, 0 = operation in progress
//
// Handshake: a cache raises req and holds it; the arbiter latches the request
// in IDLE, runs ISSUE -> BUSY -> DONE and pulses the matching ack in DONE.
// Dropping req after the grant does not cancel the transaction. Every output
// is a register whose next value is decoded from the next state.
module mem_arbiter #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              ic_ack_o,
  output logic              dc_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_dc_q, last_dc_d;   // 0 = IC granted last
  logic              gnt_dc_q, gnt_dc_d;     // current grantee
  logic              lat_we_q, lat_we_d;     // latched request type
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;
  logic              ic_ack_q, ic_ack_d;
  logic              dc_ack_q, dc_ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              pick_dc;
  logic              phase_expired;

  // Tie goes to the port that did not win last time.
  assign pick_dc       = dc_req_i & (~ic_req_i | ~last_dc_q);
  assign phase_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    gnt_dc_d  = gnt_dc_q;
    lat_we_d  = lat_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          gnt_dc_d  = pick_dc;
          last_dc_d = pick_dc;
          lat_we_d  = pick_dc ? dc_we_i : 1'b0;
          addr_d    = pick_dc ? dc_addr_i : ic_addr_i;
          wdata_d   = pick_dc ? dc_wdata_i : '0;
          cnt_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mem_ready going low means the memory accepted the operation.
        if (!mem_ready_i) begin
          cnt_d   = '0;
          state_d = S_BUSY;
        end else if (phase_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BUSY: begin
        if (mem_ready_i) begin
          if (!lat_we_q) rdata_d = mem_rdata_i;
          state_d = S_DONE;
        end else if (phase_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it.
    cs_d     = (state_d == S_ISSUE) || (state_d == S_BUSY);
    we_d     = cs_d & lat_we_d;
    oe_d     = cs_d & ~lat_we_d;
    ic_ack_d = (state_d == S_DONE) & ~gnt_dc_d;
    dc_ack_d = (state_d == S_DONE) & gnt_dc_d;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_dc_q <= 1'b0;
      gnt_dc_q  <= 1'b0;
      lat_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
      ic_ack_q  <= 1'b0;
      dc_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      gnt_dc_q  <= gnt_dc_d;
      lat_we_q  <= lat_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      ic_ack_q  <= ic_ack_d;
      dc_ack_q  <= dc_ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign ic_ack_o    = ic_ack_q;
  assign dc_ack_o    = dc_ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign mem_cs_o    = cs_q;
  assign mem_we_o    = we_q;
  assign mem_oe_o    = oe_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Inputs change 1 ns after
// a rising edge; outputs are checked at the same point, so every check sees
// the registered state produced by the edge just taken.
module tb_mem_arbiter;

  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              ic_ack;
  logic              dc_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int n_cmp;
  int n_err;

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_C3 = {16{8'hC3}};

  mem_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ic_req_i   (ic_req),
    .ic_addr_i  (ic_addr),
    .dc_req_i   (dc_req),
    .dc_we_i    (dc_we),
    .dc_addr_i  (dc_addr),
    .dc_wdata_i (dc_wdata),
    .ic_ack_o   (ic_ack),
    .dc_ack_o   (dc_ack),
    .rdata_o    (rdata),
    .err_o      (err),
    .busy_o     (busy),
    .mem_cs_o   (mem_cs),
    .mem_we_o   (mem_we),
    .mem_oe_o   (mem_oe),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b1;

    // Reset state
    #3;
    check("rst_cs", mem_cs, 0);
    check("rst_we", mem_we, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_icack", ic_ack, 0);
    check("rst_dcack", dc_ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Scenario 1: ic read of 0x10 with a two-cycle memory busy window
    ic_req  = 1'b1;
    ic_addr = 25'h10;
    step();
    check("s1_issue_cs", mem_cs, 1);
    check("s1_issue_oe", mem_oe, 1);
    check("s1_issue_we", mem_we, 0);
    check("s1_issue_addr", mem_addr, 25'h10);
    check("s1_issue_busy", busy, 1);
    mem_ready = 1'b0;
    step();
    check("s1_busy_cs", mem_cs, 1);
    check("s1_busy_ack", ic_ack, 0);
    step();
    check("s1_busy2_addr", mem_addr, 25'h10);
    mem_ready = 1'b1;
    mem_rdata = PAT_A5;
    step();
    check("s1_done_icack", ic_ack, 1);
    check("s1_done_dcack", dc_ack, 0);
    check("s1_done_rdata", rdata, PAT_A5);
    check("s1_done_err", err, 0);
    check("s1_done_cs", mem_cs, 0);
    check("s1_done_oe", mem_oe, 0);
    ic_req = 1'b0;
    step();
    check("s1_idle_ack", ic_ack, 0);
    check("s1_idle_busy", busy, 0);

    // Scenario 2: dc write at the top address; rdata must stay at A5
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 25'h1FFFFFF;
    dc_wdata = 128'h1234;
    step();
    check("s2_issue_we", mem_we, 1);
    check("s2_issue_oe", mem_oe, 0);
    check("s2_issue_addr", mem_addr, 25'h1FFFFFF);
    check("s2_issue_wdata", mem_wdata, 128'h1234);
    mem_ready = 1'b0;
    step();
    check("s2_busy_we", mem_we, 1);
    check("s2_busy_oe", mem_oe, 0);
    check("s2_busy_wdata", mem_wdata, 128'h1234);
    mem_ready = 1'b1;
    mem_rdata = 128'hDEAD;
    step();
    check("s2_done_dcack", dc_ack, 1);
    check("s2_done_icack", ic_ack, 0);
    check("s2_done_rdata", rdata, PAT_A5);
    check("s2_done_we", mem_we, 0);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    step();
    check("s2_idle_ack", dc_ack, 0);

    // Scenario 3: ties after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ic_req  = 1'b1;
    ic_addr = 25'h11;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 25'h22;
    step();
    check("s3_tie1_addr", mem_addr, 25'h22);
    check("s3_tie1_oe", mem_oe, 1);
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1;
    mem_rdata = 128'h77;
    step();
    check("s3_tie1_dcack", dc_ack, 1);
    check("s3_tie1_icack", ic_ack, 0);
    check("s3_tie1_rdata", rdata, 128'h77);
    dc_req = 1'b0;
    step();
    check("s3_gap_busy", busy, 0);
    check("s3_gap_cs", mem_cs, 0);
    // dc comes back during the idle cycle: second tie, last grant was dc
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 25'h33;
    dc_wdata = 128'h55;
    step();
    check("s3_tie2_addr", mem_addr, 25'h11);
    check("s3_tie2_we", mem_we, 0);
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1;
    mem_rdata = 128'h88;
    step();
    check("s3_tie2_icack", ic_ack, 1);
    check("s3_tie2_dcack", dc_ack, 0);
    check("s3_tie2_rdata", rdata, 128'h88);
    ic_req = 1'b0;
    step();
    check("s3_gap2_busy", busy, 0);
    step();
    check("s3_wait_addr", mem_addr, 25'h33);
    check("s3_wait_we", mem_we, 1);
    check("s3_wait_wdata", mem_wdata, 128'h55);
    mem_ready = 1'b0;
    step();
    dc_req = 1'b0;  // drop request before ack; transaction must still finish
    mem_ready = 1'b1;
    mem_rdata = 128'h99;
    step();
    check("s3_drop_dcack", dc_ack, 1);
    check("s3_drop_rdata", rdata, 128'h88);
    dc_we = 1'b0;
    step();
    step();
    check("s3_quiet_busy", busy, 0);
    check("s3_quiet_dcack", dc_ack, 0);

    // Scenario 4: memory never goes busy -> timeout after TIMEOUT cycles
    ic_req    = 1'b1;
    ic_addr   = 25'h44;
    mem_ready = 1'b1;
    step();
    check("s4_issue_cs", mem_cs, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("s4_last_issue_cs", mem_cs, 1);
    check("s4_last_issue_ack", ic_ack, 0);
    step();
    check("s4_to_icack", ic_ack, 1);
    check("s4_to_err", err, 1);
    check("s4_to_cs", mem_cs, 0);
    check("s4_to_rdata", rdata, 128'h88);
    ic_req = 1'b0;
    step();
    check("s4_after_err", err, 0);
    check("s4_after_busy", busy, 0);

    // Scenario 5: reset during BUSY
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 25'h66;
    step();
    mem_ready = 1'b0;
    step();
    check("s5_busy_cs", mem_cs, 1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_cs", mem_cs, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_dcack", dc_ack, 0);
    check("s5_rst_rdata", rdata, 0);
    check("s5_rst_addr", mem_addr, 0);
    dc_req    = 1'b0;
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("s5_post_dcack", dc_ack, 0);
    step();
    check("s5_post_busy", busy, 0);
    ic_req  = 1'b1;
    ic_addr = 25'h10;
    step();
    check("s5_new_addr", mem_addr, 25'h10);
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1;
    mem_rdata = PAT_C3;
    step();
    check("s5_new_icack", ic_ack, 1);
    check("s5_new_rdata", rdata, PAT_C3);
    check("s5_new_err", err, 0);
    ic_req = 1'b0;
    step();
    check("s5_end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
